// File: rtl/lf_adder_pkg.sv
// Shared definitions for the Ladner-Fischer adder arbiter.
//   LF_MAX_N / LF_MAX_K : largest supported operand width / requester count
//   lf_levels(n)        : prefix-network depth for an n-bit operand
//   lf_resp_t           : output slot record, sized for the largest configuration
package lf_adder_pkg;

  localparam int LF_MAX_N   = 64;
  localparam int LF_MAX_K   = 8;
  localparam int LF_MAX_IDW = $clog2(LF_MAX_K);

  function automatic int lf_levels(input int n);
    return $clog2(n);
  endfunction

  typedef struct packed {
    logic [LF_MAX_N-1:0]   sum;
    logic                  cout;
    logic                  ovf;
    logic [LF_MAX_IDW-1:0] id;
  } lf_resp_t;

endpackage

// File: rtl/lf_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter with rotating priority pointer.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (pointer returns to 0)
//   req       : per-requester request vector (K bits)
//   en        : grant enable; no grant is issued and the pointer holds when low
//   gnt       : one-hot grant, all zeros when nothing is granted
//   gnt_id    : index of the selected requester (meaningful when gnt_any)
//   gnt_any   : a grant is issued this cycle
module rr_arbiter #(
  parameter int K   = 4,
  parameter int IDW = $clog2(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K-1:0]   req,
  input  logic           en,
  output logic [K-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_any
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] sel;
  logic           found;

  // Pick the valid requester with the smallest circular distance from ptr.
  always_comb begin
    int d;
    int best;
    d     = 0;
    best  = K;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < K; i++) begin
      d = i - int'(ptr);
      if (d < 0) d = d + K;
      if (req[i] && (d < best)) begin
        best  = d;
        sel   = IDW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_id  = sel;
    gnt_any = found && en;
    gnt     = '0;
    for (int i = 0; i < K; i++) begin
      gnt[i] = gnt_any && (sel == IDW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (sel == IDW'(K - 1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: rtl/lf_adder_arbiter.sv
// One Ladner-Fischer prefix adder shared by K requesters through a round-robin
// arbiter, with a single registered, ID-tagged result slot and consumer
// backpressure.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   req_valid[K]         : per-requester operand valid
//   req_ready[K]         : one-hot accept (output), zero while rst or slot busy
//   req_a/req_b[K*N]     : packed operands, slice i = [i*N +: N]
//   req_cin[K]           : per-requester carry-in
//   resp_valid/ready     : result slot handshake
//   resp_sum/cout/ovf/id : registered sum, carry-out, signed overflow, source
// Optional feature (macro LF_ADDER_ARB_STATS_EN):
//   stat_clr             : synchronous clear of all grant counters
//   stat_grants[K*16]    : per-requester saturating 16-bit grant counters
module lf_adder_arbiter
  import lf_adder_pkg::*;
#(
  parameter int N   = 32,
  parameter int K   = 4,
  parameter int IDW = $clog2(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K-1:0]   req_valid,
  output logic [K-1:0]   req_ready,
  input  logic [K*N-1:0] req_a,
  input  logic [K*N-1:0] req_b,
  input  logic [K-1:0]   req_cin,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [N-1:0]   resp_sum,
  output logic           resp_cout,
  output logic           resp_ovf,
  output logic [IDW-1:0] resp_id
`ifdef LF_ADDER_ARB_STATS_EN
  ,
  input  logic           stat_clr,
  output logic [K*16-1:0] stat_grants
`endif
);

  localparam int LEVELS = lf_levels(N);

  // Level l combines every bit j whose bit l is set with the top bit of the
  // preceding 2^l block, doubling the covered span each level.
  function automatic logic [2*N-1:0] lf_prefix(input logic [N-1:0] g,
                                               input logic [N-1:0] p);
    logic [N-1:0] gg, pp, gn, pn;
    int k;
    gg = g;
    pp = p;
    for (int l = 0; l < LEVELS; l++) begin
      gn = gg;
      pn = pp;
      for (int j = 0; j < N; j++) begin
        if (((j >> l) & 1) == 1) begin
          k     = ((j >> l) << l) - 1;
          gn[j] = gg[j] | (pp[j] & gg[k]);
          pn[j] = pp[j] & pp[k];
        end
      end
      gg = gn;
      pp = pn;
    end
    return {gg, pp};
  endfunction

  logic           slot_free;
  logic           grant_en;
  logic [K-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           xfer;
  logic           vld_p1;
  lf_resp_t       slot_p1;

  assign slot_free = !vld_p1 || resp_ready;
  assign grant_en  = slot_free && !rst;
  assign req_ready = gnt;

  rr_arbiter #(
    .K   (K),
    .IDW (IDW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (xfer)
  );

  // ---- stage p0: operand select and prefix addition (combinational) ----
  logic [N-1:0] a_p0, b_p0, g_p0, p_p0, gg_p0, gp_p0, sum_p0;
  logic [N:0]   carry_p0;
  logic         cin_p0;
  lf_resp_t     slot_d_p0;

  always_comb begin
    a_p0   = '0;
    b_p0   = '0;
    cin_p0 = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (gnt_id == IDW'(i)) begin
        a_p0   = req_a[i*N +: N];
        b_p0   = req_b[i*N +: N];
        cin_p0 = req_cin[i];
      end
    end
  end

  always_comb begin
    g_p0             = a_p0 & b_p0;
    p_p0             = a_p0 ^ b_p0;
    {gg_p0, gp_p0}   = lf_prefix(g_p0, p_p0);
    carry_p0         = '0;
    carry_p0[0]      = cin_p0;
    for (int j = 0; j < N; j++) begin
      carry_p0[j+1] = gg_p0[j] | (gp_p0[j] & cin_p0);
    end
    sum_p0           = p_p0 ^ carry_p0[N-1:0];
    slot_d_p0.sum    = LF_MAX_N'(sum_p0);
    slot_d_p0.cout   = carry_p0[N];
    slot_d_p0.ovf    = carry_p0[N] ^ carry_p0[N-1];
    slot_d_p0.id     = LF_MAX_IDW'(gnt_id);
  end

  // ---- stage p1: result slot ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      slot_p1 <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      slot_p1 <= slot_d_p0;
    end else if (resp_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign resp_valid = vld_p1;
  assign resp_sum   = slot_p1.sum[N-1:0];
  assign resp_cout  = slot_p1.cout;
  assign resp_ovf   = slot_p1.ovf;
  assign resp_id    = slot_p1.id[IDW-1:0];

  // Slot fields are sized for the largest configuration; bits above N/IDW
  // are loaded with zeros and never read.
  logic slot_unused;
  assign slot_unused = ^{slot_p1.sum, slot_p1.id};

`ifdef LF_ADDER_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  for (genvar i = 0; i < K; i++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (stat_clr) begin
        cnt <= '0;
      end else if (gnt[i]) begin
        cnt <= sat_inc16(cnt);
      end
    end
    assign stat_grants[i*16 +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_lf_adder_arbiter.sv
// Directed bench for lf_adder_arbiter (N=8, K=4) with a result scoreboard.
module tb_lf_adder_arbiter;

  localparam int N   = 8;
  localparam int K   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [K-1:0]   req_valid;
  logic [K-1:0]   req_ready;
  logic [K*N-1:0] req_a;
  logic [K*N-1:0] req_b;
  logic [K-1:0]   req_cin;
  logic           resp_valid;
  logic           resp_ready;
  logic [N-1:0]   resp_sum;
  logic           resp_cout;
  logic           resp_ovf;
  logic [IDW-1:0] resp_id;
`ifdef LF_ADDER_ARB_STATS_EN
  logic           stat_clr;
  logic [K*16-1:0] stat_grants;
  int             mcnt [K];
`endif

  always #5 clk = ~clk;

  lf_adder_arbiter #(.N(N), .K(K), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_ovf   (resp_ovf),
    .resp_id    (resp_id)
`ifdef LF_ADDER_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants)
`endif
  );

  typedef struct packed {
    logic [N-1:0]   sum;
    logic           cout;
    logic           ovf;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mptr;
  bit   mvld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic c);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_cin[i]      = c;
  endtask

  // One clock: check the combinational grant against the reference arbiter,
  // update the scoreboard, then check the slot contents after the edge.
  task automatic cycle();
    logic [K-1:0] exp_rdy;
    logic [N-1:0] a, b;
    logic [N:0]   full;
    exp_t         e;
    int           g;
    exp_rdy = '0;
    g       = -1;
    #1;
    if (!rst && (!mvld || resp_ready)) begin
      for (int off = 0; off < K; off++) begin
        if (g < 0 && req_valid[(mptr + off) % K]) g = (mptr + off) % K;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (mvld && resp_ready && q.size() > 0) void'(q.pop_front());
    if (g >= 0) begin
      a      = req_a[g*N +: N];
      b      = req_b[g*N +: N];
      full   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, req_cin[g]};
      e.sum  = full[N-1:0];
      e.cout = full[N];
      e.ovf  = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
      e.id   = IDW'(g);
      q.push_back(e);
      mptr = (g + 1) % K;
      mvld = 1'b1;
`ifdef LF_ADDER_ARB_STATS_EN
      if (!stat_clr && mcnt[g] < 16'hFFFF) mcnt[g]++;
`endif
    end else if (resp_ready) begin
      mvld = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("resp_valid", resp_valid, mvld);
    if (mvld && q.size() > 0) begin
      chk("resp_sum", resp_sum, q[0].sum);
      chk("resp_cout", resp_cout, q[0].cout);
      chk("resp_ovf", resp_ovf, q[0].ovf);
      chk("resp_id", resp_id, q[0].id);
    end
  endtask

  task automatic check_resp(input string tag, input logic [N-1:0] s, input logic co,
                            input logic ov, input logic [IDW-1:0] id);
    chk({tag, "_sum"}, resp_sum, s);
    chk({tag, "_cout"}, resp_cout, co);
    chk({tag, "_ovf"}, resp_ovf, ov);
    chk({tag, "_id"}, resp_id, id);
  endtask

`ifdef LF_ADDER_ARB_STATS_EN
  task automatic check_stats(input string tag);
    for (int i = 0; i < K; i++) chk(tag, stat_grants[i*16 +: 16], mcnt[i]);
  endtask
`endif

  initial begin
    int start;
    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    req_cin    = '0;
    resp_ready = 1'b1;
    mptr       = 0;
    mvld       = 1'b0;
`ifdef LF_ADDER_ARB_STATS_EN
    stat_clr   = 1'b0;
    for (int i = 0; i < K; i++) mcnt[i] = 0;
`endif

    // Reset: no grants while rst is high, slot cleared.
    #12;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_resp_valid", resp_valid, 1'b0);
    check_resp("rst", 8'h00, 1'b0, 1'b0, 2'd0);
`ifdef LF_ADDER_ARB_STATS_EN
    check_stats("rst_stats");
`endif
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    chk("idle_req_ready", req_ready, 4'b0000);
    check_resp("idle", 8'h00, 1'b0, 1'b0, 2'd0);

    // Requester 2: 0xFF + 0x01 wraps with carry-out.
    set_req(2, 8'hFF, 8'h01, 1'b0);
    req_valid = 4'b0100;
    cycle();
    check_resp("r2_wrap", 8'h00, 1'b1, 1'b0, 2'd2);

    // Requester 0: positive overflow, then negative overflow with carry-in.
    set_req(0, 8'h7F, 8'h01, 1'b0);
    req_valid = 4'b0001;
    cycle();
    check_resp("r0_posovf", 8'h80, 1'b0, 1'b1, 2'd0);
    set_req(0, 8'h80, 8'h80, 1'b1);
    cycle();
    check_resp("r0_negovf", 8'h01, 1'b1, 1'b1, 2'd0);
    req_valid = 4'b0000;
    cycle();

    // All requesters valid: one grant per cycle in rotating order.
    for (int i = 0; i < K; i++) set_req(i, 8'h10 * i + 8'h3, 8'hE0 + 8'(i * 7), i[0]);
    req_valid = 4'b1111;
    start     = mptr;
    for (int i = 0; i < 2 * K; i++) begin
      cycle();
      chk("rr_order", resp_id, (start + i) % K);
    end

    // Backpressure with requesters 1 and 3 pending: slot holds, no grants.
    resp_ready = 1'b0;
    req_valid  = 4'b1010;
    set_req(1, 8'h55, 8'h2B, 1'b1);
    set_req(3, 8'hC0, 8'h90, 1'b0);
    repeat (3) cycle();
    resp_ready = 1'b1;
    #1;
    chk("bp_release_grant", req_ready, 4'b0010);
    cycle();
    chk("bp_next_id", resp_id, 2'd1);
    cycle();
    chk("bp_after_id", resp_id, 2'd3);
`ifdef LF_ADDER_ARB_STATS_EN
    check_stats("stats_count");
`endif

    // Asynchronous reset with a valid result in the slot.
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 4'b0000);
    check_resp("midrst", 8'h00, 1'b0, 1'b0, 2'd0);
    q.delete();
    mptr = 0;
    mvld = 1'b0;
`ifdef LF_ADDER_ARB_STATS_EN
    for (int i = 0; i < K; i++) mcnt[i] = 0;
    check_stats("midrst_stats");
`endif
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    cycle();
    chk("post_rst_id", resp_id, 2'd0);
    cycle();
    req_valid = 4'b0000;
    cycle();
    cycle();

`ifdef LF_ADDER_ARB_STATS_EN
    check_stats("stats_final");
    stat_clr  = 1'b1;
    req_valid = 4'b1111;
    cycle();
    stat_clr  = 1'b0;
    req_valid = 4'b0000;
    for (int i = 0; i < K; i++) mcnt[i] = 0;
    check_stats("stats_clr");
    cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lf_adder_arbiter.md
Name: lf_adder_arbiter

Overview:
- Shares one N-bit Ladner-Fischer prefix adder datapath between K independent requesters.
- Each requester presents operands with a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the sum is computed combinationally through the prefix network.
- The result is registered in a single output slot tagged with the requester ID, with backpressure from the consumer.
- Sits between operand-producing units and a common result bus in the arithmetic subsystem.

Parameters:
- N, 32, operand width in bits; power of two, 4..64.
- K, 4, number of requesters; 2..8.
- IDW, $clog2(K), width of the requester ID tag.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- req_valid, input, K, per-requester request valid.
- req_ready, input→output, K, one-hot grant/accept; req_ready[i] is an output.
- req_a, input, K*N, packed operand A; slice i = [i*N +: N].
- req_b, input, K*N, packed operand B.
- req_cin, input, K, per-requester carry-in.
- resp_valid, output, 1, result slot holds valid data.
- resp_ready, input, 1, consumer accepts the result.
- resp_sum, output, N, registered sum.
- resp_cout, output, 1, registered carry-out.
- resp_ovf, output, 1, registered signed overflow.
- resp_id, output, IDW, index of the requester that produced the result.

Behaviour:
- Reset (asynchronous, rst=1):
  - resp_valid=0; resp_sum, resp_cout, resp_ovf and resp_id all 0.
  - RR pointer=0.
  - req_ready=0 while rst is asserted.
- slot_free = !resp_valid || resp_ready (combinational).
- Arbitration:
  - When slot_free, grant goes to the first i with req_valid[i]=1, searching i = ptr, ptr+1, … mod K.
  - req_ready = one-hot grant; all zeros if nothing is valid or !slot_free.
  - req_ready depends on req_valid, but req_valid must never depend on req_ready.
- Transfer: a request transfers on req_valid[i] && req_ready[i].
  - On the same edge the slot loads the sum for requester i: resp_valid=1, resp_id=i.
  - ptr updates to (i+1) mod K.
  - ptr is unchanged when there is no grant.
- Datapath, computed from the granted slice:
  - g = a&b, p = a^b.
  - (G,P) = prefix over bits 0..N-1, using the Ladner-Fischer structure (log2 N levels, odd-span combine per level).
  - c[0]=cin; c[j+1] = G[j] | (P[j] & cin).
  - sum[j] = p[j]^c[j]; cout = c[N]; ovf = c[N]^c[N-1].
- Latency: exactly 1 cycle from accepting edge to resp_valid=1.
- Throughput: 1 result per cycle when resp_ready is held at 1.
- Output hold: while resp_valid && !resp_ready, all resp_* outputs hold stable and req_ready=0.
- Simultaneous consume and grant: resp_ready=1 with a pending request accepts the new request in the same cycle. The slot is overwritten with the new result, with no bubble.
- Consume with no new grant: resp_valid drops to 0 on the next edge.
- Fairness: a requester holding valid is granted within K grant opportunities.
- Requester protocol: after asserting req_valid, a requester must hold its operands stable until accepted. The block does not check this.
- Reset mid-operation: an in-flight result is discarded and ptr returns to 0.
- Wrap-around: all arithmetic is modulo 2^N; the carry is reported via cout.

Optional Feature:
- Macro: LF_ADDER_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants, width K*16: per-requester 16-bit grant counters.
  - Each counter increments on its requester's accepted transfer and saturates at 0xFFFF.
  - Counters clear on rst.
  - Adds input stat_clr, width 1: synchronous clear of all counters. stat_clr takes priority over a same-cycle increment.
- Undefined: no stat ports and no counter logic; all other behaviour is identical.

Decomposition:
- Package lf_adder_pkg:
  - LF_MAX_N=64 and LF_MAX_K=8 limits.
  - Function lf_levels(N) = $clog2(N).
  - Typedef lf_resp_t {sum, cout, ovf, id}, used for the output slot register.
- One natural sub-module: rr_arbiter (K requesters, ptr register, one-hot grant, grant-enable input). This lets fairness be verified standalone.
- The prefix adder stays as combinational logic in the top module.

Test Plan:
- N=8, K=4; reset, then idle: resp_valid=0, req_ready=0, all resp_* outputs = 0.
- Single request, requester 2: a=0xFF, b=0x01, cin=0, resp_ready=1 → next cycle resp_sum=0x00, cout=1, ovf=0, id=2.
- Single request, requester 0: a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=1 → sum=0x01, cout=1, ovf=1.
- All 4 valid continuously, resp_ready=1 → grants 0,1,2,3,0,… one per cycle, and resp_id follows the same order one cycle later.
- Backpressure: resp_ready=0 for 3 cycles with requesters 1 and 3 valid → req_ready=0 and the slot holds stable. On resp_ready=1 the held result is consumed and the next grant goes to requester 1 in the same cycle, with no bubble.
- Assert rst mid-stream with resp_valid=1 → resp_valid=0 immediately (asynchronous). After release the first grant goes to requester 0. With LF_ADDER_ARB_STATS_EN, all counters read 0.
